// File: rtl/pdp8_mem_ctrl_if.sv
// pdp8_mem_ctrl_if.sv
// Request/response bus between the IFU, exec unit and memory controller.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface pdp8_mem_ctrl_if;
    logic                   ifu_rd_req;
    logic [`ADDR_WIDTH-1:0] ifu_rd_addr;
    logic [`DATA_WIDTH-1:0] ifu_rd_data;
    logic                   ifu_rd_vld;
    logic                   exec_rd_req;
    logic [`ADDR_WIDTH-1:0] exec_rd_addr;
    logic [`DATA_WIDTH-1:0] exec_rd_data;
    logic                   exec_rd_vld;
    logic                   exec_wr_req;
    logic [`ADDR_WIDTH-1:0] exec_wr_addr;
    logic [`DATA_WIDTH-1:0] exec_wr_data;
    logic                   exec_wr_ack;

    modport master (
        output ifu_rd_req, ifu_rd_addr,
        input  ifu_rd_data, ifu_rd_vld,
        output exec_rd_req, exec_rd_addr,
        input  exec_rd_data, exec_rd_vld,
        output exec_wr_req, exec_wr_addr, exec_wr_data,
        input  exec_wr_ack
    );

    modport slave (
        input  ifu_rd_req, ifu_rd_addr,
        output ifu_rd_data, ifu_rd_vld,
        input  exec_rd_req, exec_rd_addr,
        output exec_rd_data, exec_rd_vld,
        input  exec_wr_req, exec_wr_addr, exec_wr_data,
        output exec_wr_ack
    );
endinterface

// File: rtl/pdp8_mem_ctrl.sv
// pdp8_mem_ctrl.sv
// Single-port 12-bit core memory, three requestors, fixed priority, fill.
module pdp8_mem_ctrl #(
    parameter int INIT_EN   = 1,
    parameter int MEM_DEPTH = 4096
) (
    input  logic           clk,
    input  logic           reset,
    pdp8_mem_ctrl_if.slave bus,
    output logic           busy,
    output logic           proto_err
);
    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_SERVE = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_fill;
    logic [DW-1:0] r_mem [MEM_DEPTH];

    logic          r_wr_pend;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_erd_pend;
    logic [AW-1:0] r_erd_addr;
    logic          r_ird_pend;
    logic [AW-1:0] r_ird_addr;

    logic [DW-1:0] r_erd_data;
    logic [DW-1:0] r_ird_data;
    logic          r_erd_vld;
    logic          r_ird_vld;
    logic          r_wr_ack;
    logic          r_err;

    logic          w_init;
    logic          w_fill_last;
    logic          w_srv_wr;
    logic          w_srv_erd;
    logic          w_srv_ird;
    logic          w_any_pend;
    logic          w_nxt_pend;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wd;

    assign w_init      = (r_state == S_INIT);
    assign w_fill_last = (r_fill == AW'(MEM_DEPTH - 1));

    // Fixed priority: write beats exec read beats IFU read.
    assign w_srv_wr  = !w_init && r_wr_pend;
    assign w_srv_erd = !w_init && r_erd_pend && !r_wr_pend;
    assign w_srv_ird = !w_init && r_ird_pend && !r_wr_pend
                       && !r_erd_pend;

    assign w_any_pend = r_wr_pend || r_erd_pend || r_ird_pend;
    assign w_nxt_pend =
        bus.exec_wr_req || (r_wr_pend && !w_srv_wr) ||
        bus.exec_rd_req || (r_erd_pend && !w_srv_erd) ||
        bus.ifu_rd_req || (r_ird_pend && !w_srv_ird);

    // The single array port is shared by the fill and the winning slot.
    assign w_mem_we   = !reset && (w_init || w_srv_wr);
    assign w_mem_addr = w_init    ? r_fill :
                        w_srv_wr  ? r_wr_addr :
                        w_srv_erd ? r_erd_addr : r_ird_addr;
    assign w_mem_wd   = w_init ? DW'(r_fill) : r_wr_data;

    // Controller state and fill address counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= (INIT_EN != 0) ? S_INIT : S_IDLE;
            r_fill  <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_fill <= w_fill_last ? '0 : r_fill + 1'b1;
                    if (w_fill_last) r_state <= S_IDLE;
                end
                S_IDLE:  if (w_any_pend) r_state <= S_SERVE;
                S_SERVE: if (!w_nxt_pend) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pending slots: a new pulse overwrites, service clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_pend  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_erd_pend <= 1'b0;
            r_erd_addr <= '0;
            r_ird_pend <= 1'b0;
            r_ird_addr <= '0;
        end else begin
            if (bus.exec_wr_req) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= bus.exec_wr_addr;
                r_wr_data <= bus.exec_wr_data;
            end else if (w_srv_wr) begin
                r_wr_pend <= 1'b0;
            end
            if (bus.exec_rd_req) begin
                r_erd_pend <= 1'b1;
                r_erd_addr <= bus.exec_rd_addr;
            end else if (w_srv_erd) begin
                r_erd_pend <= 1'b0;
            end
            if (bus.ifu_rd_req) begin
                r_ird_pend <= 1'b1;
                r_ird_addr <= bus.ifu_rd_addr;
            end else if (w_srv_ird) begin
                r_ird_pend <= 1'b0;
            end
        end
    end

    // Sticky error when a slot is overwritten before it was served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((bus.exec_wr_req && r_wr_pend && !w_srv_wr) ||
                     (bus.exec_rd_req && r_erd_pend && !w_srv_erd) ||
                     (bus.ifu_rd_req && r_ird_pend && !w_srv_ird)) begin
            r_err <= 1'b1;
        end
    end

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wd;
    end

    // Registered read data, held until that port's next service.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_erd_data <= '0;
            r_ird_data <= '0;
        end else begin
            if (w_srv_erd) r_erd_data <= r_mem[w_mem_addr];
            if (w_srv_ird) r_ird_data <= r_mem[w_mem_addr];
        end
    end

    // One-cycle strobes following each service.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ack  <= 1'b0;
            r_erd_vld <= 1'b0;
            r_ird_vld <= 1'b0;
        end else begin
            r_wr_ack  <= w_srv_wr;
            r_erd_vld <= w_srv_erd;
            r_ird_vld <= w_srv_ird;
        end
    end

    assign bus.exec_wr_ack  = r_wr_ack;
    assign bus.exec_rd_vld  = r_erd_vld;
    assign bus.exec_rd_data = r_erd_data;
    assign bus.ifu_rd_vld   = r_ird_vld;
    assign bus.ifu_rd_data  = r_ird_data;
    assign busy             = w_init;
    assign proto_err        = r_err;
endmodule
